sram_sp_rsp: RTL and testbench

- Single-port synchronous word SRAM with a valid/ready request channel and a valid/ready response channel.
- Internal response-pending flag: set on request handshake, cleared on response handshake, set wins on a tie.
- Read address is held while the response is stalled, so read data stays stable until accepted.
- Instantiated behind bus-to-SRAM adapters as the memory back-end: instruction/data RAM.

---
 rtl/sram_sp_rsp_if.sv | 41 ++++
 rtl/sram_sp_rsp.sv | 158 +++++++++++++++
 tb/tb_sram_sp_rsp.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_sp_rsp_if.sv
// ---------------------------------------------------------------------------
// sram_sp_rsp_if
//   Request/response bundle for the single-port SRAM back-end.
//
//   Handshake rule (both channels): a transfer happens on a rising clock edge
//   where valid and ready are both high. The producer holds valid and its
//   payload until that edge, and the consumer may raise or lower ready at any
//   time.
//
//   Request channel  (master -> slave): req_vld, req_wen, req_addr,
//                                        req_wdata, req_wstrb
//                    (slave -> master): req_rdy
//   Response channel (slave -> master): rsp_vld, rsp_rdata
//                    (master -> slave): rsp_rdy
//
//   Parameters: DW (data width, multiple of 8), SRAM_AW (word-address width).
// ---------------------------------------------------------------------------
interface sram_sp_rsp_if #(
    parameter int DW      = 32,
    parameter int SRAM_AW = 15
);
    logic                 req_vld;
    logic                 req_rdy;
    logic                 req_wen;
    logic [SRAM_AW-1:0]   req_addr;
    logic [DW-1:0]        req_wdata;
    logic [DW/8-1:0]      req_wstrb;
    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic [DW-1:0]        rsp_rdata;

    modport master (
        output req_vld, req_wen, req_addr, req_wdata, req_wstrb, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wen, req_addr, req_wdata, req_wstrb, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );
endinterface

// File: rtl/sram_sp_rsp.sv
// ---------------------------------------------------------------------------
// sram_sp_rsp
//   Single-port synchronous word SRAM with valid/ready request and response
//   channels. It serves as the memory back-end behind bus-to-SRAM adapters.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous, active-high reset (clears the pending flag and the
//            held address, but not the array contents)
//     bus  - sram_sp_rsp_if.slave (request and response channels)
//
//   Behaviour:
//     - One-cycle read latency. A request accepted in cycle N has rsp_vld=1
//       and valid rsp_rdata in cycle N+1.
//     - Every accepted request, read or write, produces exactly one response.
//       For a write the response is the acknowledgement, and rsp_rdata shows
//       the merged new word (write-first).
//     - While the response is stalled, the array re-reads the held address,
//       so rsp_rdata stays stable until it is accepted.
//     - req_rdy = ~rsp_vld | rsp_rdy. This gives back-to-back operation at
//       one transaction per cycle while rsp_rdy is high.
//
//   Configuration macro:
//     SRAM_BYTE_WSTRB_EN - when defined, req_wstrb gates individual bytes.
//                          When undefined, req_wstrb is ignored and every
//                          write updates the full word.
// ---------------------------------------------------------------------------
module sram_sp_rsp #(
    parameter int DW      = 32,   // must be a multiple of 8
    parameter int SRAM_AW = 15
) (
    input  logic         clk,
    input  logic         rst,
    sram_sp_rsp_if.slave bus
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << SRAM_AW;

    // The response-pending flag is the only control state. It is kept as a
    // named enum so that the state is visible on a waveform, and rsp_vld is
    // taken directly from it.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t              state;
    logic                req_hsk;
    logic                rsp_hsk;
    logic                mem_we;
    logic [SRAM_AW-1:0]  addr_pend;
    logic [SRAM_AW-1:0]  arr_addr;
    logic [NB-1:0]       byte_en;
    logic [DW-1:0]       bit_mask;
    logic [DW-1:0]       old_word;
    logic [DW-1:0]       wr_word;
    logic [DW-1:0]       rdata_q;
    logic [DW-1:0]       mem [DEPTH];

    // ---------------------------------------------------------------------
    // Handshakes
    // ---------------------------------------------------------------------
    assign bus.rsp_vld   = (state == ST_PEND);
    assign bus.req_rdy   = ~bus.rsp_vld | bus.rsp_rdy;
    assign bus.rsp_rdata = rdata_q;

    assign req_hsk = bus.req_vld & bus.req_rdy;
    assign rsp_hsk = bus.rsp_vld & bus.rsp_rdy;

    // A new request steers the array to its own address. Otherwise the array
    // keeps reading the address of the outstanding response, which holds
    // rsp_rdata steady during a stall.
    assign arr_addr = req_hsk ? bus.req_addr : addr_pend;

    // ---------------------------------------------------------------------
    // Write byte enables
    // ---------------------------------------------------------------------
`ifdef SRAM_BYTE_WSTRB_EN
    assign byte_en = bus.req_wstrb;
`else
    // The strobe port is present but ignored: every write covers the whole
    // word.
    logic unused_wstrb;
    assign unused_wstrb = ^bus.req_wstrb;
    assign byte_en      = {NB{1'b1}};
`endif

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < NB; i++) begin
            bit_mask[8*i +: 8] = {8{byte_en[i]}};
        end
    end

    // This merged word is used only for the write-first response data. The
    // array itself is updated byte by byte below.
    assign old_word = mem[bus.req_addr];
    assign wr_word  = (bus.req_wdata & bit_mask) | (old_word & ~bit_mask);

    // No write may land during a reset cycle, even when a request handshake
    // happens to coincide with it.
    assign mem_we = req_hsk & bus.req_wen & ~rst;

    // ---------------------------------------------------------------------
    // Control state: pending flag and held address.
    // When a request and a response handshake happen together, the set
    // wins, which keeps the back-to-back stream valid.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_pend <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_hsk) begin
                        state     <= ST_PEND;
                        addr_pend <= bus.req_addr;
                    end
                end
                ST_PEND: begin
                    if (req_hsk) begin
                        state     <= ST_PEND;
                        addr_pend <= bus.req_addr;
                    end else if (rsp_hsk) begin
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Storage array (not reset)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port. When a write happens in the same cycle,
    // arr_addr equals the write address, so returning the merged word gives
    // write-first behaviour.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            rdata_q <= wr_word;
        end else begin
            rdata_q <= mem[arr_addr];
        end
    end

endmodule

// File: tb/tb_sram_sp_rsp.sv
// ---------------------------------------------------------------------------
// tb_sram_sp_rsp
//   Self-checking bench for sram_sp_rsp. It runs in this order:
//     1. reset and idle checks
//     2. a table of directed per-cycle vectors
//     3. a reset-in-the-middle-of-a-transaction sequence
//     4. randomized traffic checked against a memory-array + response-queue
//        reference model
// ---------------------------------------------------------------------------
module tb_sram_sp_rsp;
    localparam int DW = 32;
    localparam int AW = 15;

`ifdef SRAM_BYTE_WSTRB_EN
    localparam logic [DW-1:0] EXP_STRB = 32'h11BB33DD;
`else
    localparam logic [DW-1:0] EXP_STRB = 32'hAABBCCDD;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_sp_rsp_if #(.DW(DW), .SRAM_AW(AW)) bus ();

    sram_sp_rsp #(.DW(DW), .SRAM_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [int];

    typedef struct {
        logic          vld;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        logic          rdy;
        logic          exp_rdy;
        logic          exp_vld;
        logic          chk;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t rows[$];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic vld, input logic wen,
                                input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata,
                                input logic [3:0] wstrb, input logic rdy,
                                input logic exp_rdy, input logic exp_vld,
                                input logic chk,
                                input logic [DW-1:0] exp_data);
        vec_t v;
        v.vld = vld; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.wstrb = wstrb; v.rdy = rdy; v.exp_rdy = exp_rdy;
        v.exp_vld = exp_vld; v.chk = chk; v.exp_data = exp_data;
        rows.push_back(v);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wdata,
                                            input logic [3:0] wstrb);
        logic [DW-1:0] r;
`ifdef SRAM_BYTE_WSTRB_EN
        r = old;
        for (int i = 0; i < 4; i++)
            if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
`else
        r = wdata;
        if (wstrb == 4'hF && old == '1) r = wdata;
`endif
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic vld, input logic wen,
                         input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata,
                         input logic [3:0] wstrb, input logic rdy);
        bus.req_vld   = vld;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        bus.rsp_rdy   = rdy;
    endtask

    // One cycle of traffic checked against the reference model. The model
    // tracks the outstanding responses in exp_q: a request is accepted when
    // nothing is outstanding or the outstanding response is taken in the
    // same cycle.
    task automatic do_cycle(input logic vld, input logic wen,
                            input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata,
                            input logic [3:0] wstrb, input logic rdy);
        logic can;
        logic [DW-1:0] old;
        @(negedge clk);
        drive(vld, wen, addr, wdata, wstrb, rdy);
        #1;
        can = (exp_q.size() == 0) || rdy;
        check("rnd req_rdy", {31'd0, bus.req_rdy}, {31'd0, can});
        if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
        if (vld && can) begin
            if (wen) begin
                old = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : '0;
                model_mem[int'(addr)] = merge(old, wdata, wstrb);
            end
            exp_q.push_back(model_mem[int'(addr)]);
        end
        @(posedge clk);
        #1;
        check("rnd rsp_vld", {31'd0, bus.rsp_vld}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) check("rnd rsp_rdata", bus.rsp_rdata, exp_q[0]);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Directed per-cycle vectors:
        //  vld wen addr  wdata  strb rdy | req_rdy rsp_vld chk data
        add(1, 1, 'h10, 32'hDEADBEEF, 4'hF, 1,  1, 1, 1, 32'hDEADBEEF);
        add(1, 0, 'h10, 32'h0,        4'h0, 1,  1, 1, 1, 32'hDEADBEEF);
        add(0, 0, 'h00, 32'h0,        4'h0, 1,  1, 0, 0, 32'h0);
        add(1, 1, 'h20, 32'h11223344, 4'hF, 1,  1, 1, 1, 32'h11223344);
        add(1, 1, 'h20, 32'hAABBCCDD, 4'h5, 1,  1, 1, 1, EXP_STRB);
        add(1, 0, 'h20, 32'h0,        4'h0, 1,  1, 1, 1, EXP_STRB);
        add(1, 1, 'h01, 32'd1,        4'hF, 1,  1, 1, 1, 32'd1);
        add(1, 1, 'h02, 32'd2,        4'hF, 1,  1, 1, 1, 32'd2);
        add(1, 1, 'h03, 32'd3,        4'hF, 1,  1, 1, 1, 32'd3);
        add(1, 0, 'h01, 32'h0,        4'h0, 1,  1, 1, 1, 32'd1);
        add(1, 0, 'h02, 32'h0,        4'h0, 1,  1, 1, 1, 32'd2);
        add(1, 0, 'h03, 32'h0,        4'h0, 1,  1, 1, 1, 32'd3);
        add(0, 0, 'h00, 32'h0,        4'h0, 1,  1, 0, 0, 32'h0);
        // stall: four cycles with rsp_rdy=0, including a refused write
        add(1, 0, 'h10, 32'h0,        4'h0, 0,  1, 1, 1, 32'hDEADBEEF);
        add(0, 0, 'h00, 32'h0,        4'h0, 0,  0, 1, 1, 32'hDEADBEEF);
        add(0, 0, 'h00, 32'h0,        4'h0, 0,  0, 1, 1, 32'hDEADBEEF);
        add(1, 1, 'h10, 32'h0,        4'hF, 0,  0, 1, 1, 32'hDEADBEEF);
        add(0, 0, 'h00, 32'h0,        4'h0, 1,  1, 0, 0, 32'h0);
        add(1, 0, 'h10, 32'h0,        4'h0, 1,  1, 1, 1, 32'hDEADBEEF);
        add(0, 0, 'h00, 32'h0,        4'h0, 1,  1, 0, 0, 32'h0);

        // Reset, then idle
        rst = 1'b1;
        drive(0, 0, '0, '0, 4'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        check("reset req_rdy", {31'd0, bus.req_rdy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("idle rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        end

        // Table-driven directed vectors
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            drive(rows[i].vld, rows[i].wen, rows[i].addr, rows[i].wdata,
                  rows[i].wstrb, rows[i].rdy);
            #1;
            check($sformatf("row%0d req_rdy", i), {31'd0, bus.req_rdy},
                  {31'd0, rows[i].exp_rdy});
            @(posedge clk);
            #1;
            check($sformatf("row%0d rsp_vld", i), {31'd0, bus.rsp_vld},
                  {31'd0, rows[i].exp_vld});
            if (rows[i].chk)
                check($sformatf("row%0d rsp_rdata", i), bus.rsp_rdata,
                      rows[i].exp_data);
        end

        // Reset in the middle of a transaction
        @(negedge clk);
        drive(1, 0, 'h10, '0, 4'h0, 0);
        @(posedge clk);
        #1;
        check("midrst pre rsp_vld", {31'd0, bus.rsp_vld}, 32'd1);
        check("midrst pre rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, '0, '0, 4'h0, 0);
        @(posedge clk);
        #1;
        check("midrst rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        // A write presented during reset must not reach the array.
        @(negedge clk);
        drive(1, 1, 'h10, 32'h0, 4'hF, 1);
        #1;
        check("midrst req_rdy", {31'd0, bus.req_rdy}, 32'd1);
        @(posedge clk);
        #1;
        check("midrst wr rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, '0, '0, 4'h0, 1);
        model_mem[16] = 32'hDEADBEEF;
        do_cycle(1, 0, 'h10, '0, 4'h0, 1);
        do_cycle(0, 0, '0, '0, 4'h0, 1);

        // Randomized traffic: first fill addresses 0..15 with full words,
        // then run mixed reads and writes with random back-pressure.
        for (int a = 0; a < 16; a++)
            do_cycle(1, 1, AW'(a), $urandom, 4'hF, 1);
        for (int n = 0; n < 400; n++) begin
            do_cycle($urandom_range(0, 9) < 7,
                     $urandom_range(0, 1) == 1,
                     AW'($urandom_range(0, 15)),
                     $urandom,
                     4'($urandom_range(0, 15)),
                     $urandom_range(0, 3) != 0);
        end
        do_cycle(0, 0, '0, '0, 4'h0, 1);
        do_cycle(0, 0, '0, '0, 4'h0, 1);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
